// File: rtl/fram_log_writer.sv
// Appends valid/ready byte records to a log region of an SPI FRAM (WREN, WRITE, addr, data).
// Define FRAM_LOG_WRAP_EN for a circular log; otherwise writing stops and full latches at the end.
module fram_log_writer #(
  parameter logic [15:0] LOG_BASE = 16'h0000,
  parameter logic [15:0] LOG_SIZE = 16'h2000,
  parameter int          CS_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  rec_len,
  input  logic        log_clear,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs,
  output logic [15:0] log_addr,
  output logic        full,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_GAP, S_HDR, S_WAIT,
    S_DATA, S_END, S_DONE, S_DISC
  } state_t;

  localparam logic [15:0] LAST = 16'(LOG_BASE + LOG_SIZE - 16'd1);

  state_t      r_state;
  state_t      r_next;
  logic [23:0] r_sh;
  logic [4:0]  r_cnt;
  logic        r_ph;
  logic [7:0]  r_gap;
  logic [5:0]  r_rem;
  logic [15:0] r_addr;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_cs;
  logic        w_last;
  logic        w_full;

`ifdef FRAM_LOG_WRAP_EN
  assign w_full = 1'b0;
`else
  logic r_full;
  assign w_full = r_full;
`endif

  assign w_last     = (r_addr == LAST);
  assign data_ready = (r_state == S_WAIT) || (r_state == S_DISC);
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign spi_clk    = r_sclk;
  assign spi_mosi   = r_mosi;
  assign spi_cs     = r_cs;
  assign log_addr   = r_addr;
  assign full       = w_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_next  <= S_DONE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_ph    <= 1'b0;
      r_gap   <= '0;
      r_rem   <= '0;
      r_addr  <= LOG_BASE;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs    <= 1'b1;
`ifndef FRAM_LOG_WRAP_EN
      r_full  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (log_clear) begin
            r_addr <= LOG_BASE;
`ifndef FRAM_LOG_WRAP_EN
            r_full <= 1'b0;
`endif
          end else if (start) begin
            if (rec_len == 6'd0) begin
              r_state <= S_DONE;
            end else begin
              r_rem <= rec_len;
              if (w_full) begin
                r_state <= S_DISC;
              end else begin
                r_state <= S_WREN;
                r_sh    <= {8'h06, 16'h0000};
                r_cnt   <= 5'd7;
                r_ph    <= 1'b0;
                r_cs    <= 1'b0;
                r_mosi  <= 1'b0;
              end
            end
          end
        end
        S_WREN, S_HDR, S_DATA: begin
          if (!r_ph) begin
            r_sclk <= 1'b1;
            r_ph   <= 1'b1;
          end else begin
            r_sclk <= 1'b0;
            r_ph   <= 1'b0;
            if (r_cnt != 5'd0) begin
              r_cnt  <= r_cnt - 5'd1;
              r_sh   <= r_sh << 1;
              r_mosi <= r_sh[22];
            end else begin
              r_mosi <= 1'b0;
              if (r_state == S_WREN) begin
                r_state <= S_GAP;
                r_cs    <= 1'b1;
                r_gap   <= 8'(CS_GAP - 1);
              end else if (r_state == S_HDR) begin
                r_state <= S_WAIT;
              end else begin
                r_rem <= r_rem - 6'd1;
`ifdef FRAM_LOG_WRAP_EN
                r_addr <= w_last ? LOG_BASE : r_addr + 16'd1;
`else
                r_addr <= r_addr + 16'd1;
                if (w_last) r_full <= 1'b1;
`endif
                if (r_rem == 6'd1) begin
                  r_state <= S_END;
                  r_cs    <= 1'b1;
                  r_next  <= S_DONE;
                end else if (w_last) begin
                  r_state <= S_END;
                  r_cs    <= 1'b1;
`ifdef FRAM_LOG_WRAP_EN
                  r_next  <= S_WREN;
`else
                  r_next  <= S_DISC;
`endif
                end else begin
                  r_state <= S_WAIT;
                end
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap == 8'd0) begin
            r_state <= S_HDR;
            r_sh    <= {8'h02, r_addr};
            r_cnt   <= 5'd23;
            r_ph    <= 1'b0;
            r_cs    <= 1'b0;
            r_mosi  <= 1'b0;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        S_WAIT: begin
          if (data_valid) begin
            r_state <= S_DATA;
            r_sh    <= {data_in, 16'h0000};
            r_cnt   <= 5'd7;
            r_ph    <= 1'b0;
            r_mosi  <= data_in[7];
          end
        end
        S_END: begin
          r_state <= r_next;
          // a wrapped record restarts with a fresh WREN frame at LOG_BASE
          if (r_next == S_WREN) begin
            r_sh   <= {8'h06, 16'h0000};
            r_cnt  <= 5'd7;
            r_ph   <= 1'b0;
            r_cs   <= 1'b0;
            r_mosi <= 1'b0;
          end
        end
        S_DISC: begin
          if (data_valid) begin
            r_rem <= r_rem - 6'd1;
            if (r_rem == 6'd1) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fram_log_writer.sv
// Random-record bench for fram_log_writer: SPI frames decoded off the bus
// and compared with a byte-level model of the log.
module tb_fram_log_writer;

  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [15:0] SIZE = 16'h0010;
  localparam int          GAP  = 2;
  localparam int          SEP  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rec_len = '0;
  logic        log_clear = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_cs;
  logic [15:0] log_addr;
  logic        full;
  logic        busy;
  logic        done;

  fram_log_writer #(
    .LOG_BASE(BASE),
    .LOG_SIZE(SIZE),
    .CS_GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rec_len(rec_len),
    .log_clear(log_clear),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_cs(spi_cs),
    .log_addr(log_addr),
    .full(full),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bus monitor: frames as byte lists, each closed by SEP
  int   mon_q[$];
  int   exp_q[$];
  int   fr_b[$];
  logic [7:0] sh = '0;
  int   nb = 0;
  int   hi_cnt = 0;
  int   cs_falls = 0;
  bit   last_wren = 0;
  logic p_cs = 1'b1;
  logic p_sclk = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      fr_b.delete();
      nb = 0;
      last_wren = 0;
      p_cs = 1'b1;
      p_sclk = 1'b0;
      hi_cnt = 0;
    end else begin
      if (!p_sclk && spi_clk && !spi_cs) begin
        sh = {sh[6:0], spi_mosi};
        nb++;
        if (nb == 8) begin
          fr_b.push_back(int'(sh));
          nb = 0;
        end
      end
      if (spi_cs) hi_cnt++;
      if (p_cs && !spi_cs) begin
        cs_falls++;
        if (last_wren) chk("cs_gap", hi_cnt, GAP);
        hi_cnt = 0;
      end
      if (!p_cs && spi_cs) begin
        last_wren = (fr_b.size() == 1 && fr_b[0] == 6 && nb == 0);
        foreach (fr_b[i]) mon_q.push_back(fr_b[i]);
        if (nb != 0) mon_q.push_back(999);
        mon_q.push_back(SEP);
        fr_b.delete();
        nb = 0;
      end
      p_cs = spi_cs;
      p_sclk = spi_clk;
    end
  end

  logic [15:0] m_addr = BASE;
  bit          m_full = 0;

  task automatic flush(inout int cur[$]);
    foreach (cur[j]) exp_q.push_back(cur[j]);
    exp_q.push_back(SEP);
    cur.delete();
  endtask

  task automatic model_rec(input int bq[$]);
    bit open = 0;
    int cur[$];
    foreach (bq[i]) begin
      if (m_full) continue;
      if (!open) begin
        exp_q.push_back(6);
        exp_q.push_back(SEP);
        cur.push_back(2);
        cur.push_back(int'(m_addr[15:8]));
        cur.push_back(int'(m_addr[7:0]));
        open = 1;
      end
      cur.push_back(bq[i]);
      if (m_addr == 16'(BASE + SIZE - 1)) begin
`ifdef FRAM_LOG_WRAP_EN
        m_addr = BASE;
`else
        m_addr = 16'(BASE + SIZE);
        m_full = 1;
`endif
        flush(cur);
        open = 0;
      end else begin
        m_addr = m_addr + 16'd1;
      end
    end
    if (open) flush(cur);
  endtask

  task automatic cmp_frames();
    int n;
    chk("frame_len", mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("frame_byte", mon_q[i], exp_q[i]);
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic run_rec(input int bq[$], input int stall_at);
    int t;
    int bad;
    int f0;
    f0 = cs_falls;
    model_rec(bq);
    @(negedge clk);
    start = 1'b1;
    rec_len = 6'(bq.size());
    foreach (bq[i]) begin
      if (i == stall_at) begin
        t = 0;
        while (!data_ready && t < 400) begin
          @(negedge clk);
          t++;
        end
        bad = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (!(data_ready && !spi_clk && !spi_cs)) bad++;
        end
        chk("stall_static", bad, 0);
      end
      data_in = 8'(bq[i]);
      data_valid = 1'b1;
      t = 0;
      while (!data_ready && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) chk("ready_timeout", t, 0);
      else @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
    end
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("log_addr", log_addr, m_addr);
    chk("full", full, m_full);
    if (bq.size() == 0) chk("no_cs_len0", cs_falls - f0, 0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("done_clr", done, 0);
    cmp_frames();
  endtask

  task automatic do_clear();
    @(negedge clk);
    log_clear = 1'b1;
    @(negedge clk);
    log_clear = 1'b0;
    m_addr = BASE;
    m_full = 0;
    chk("clr_addr", log_addr, BASE);
    chk("clr_full", full, 0);
  endtask

  task automatic rand_rec(input int n);
    int bq[$];
    for (int i = 0; i < n; i++) bq.push_back(int'($urandom_range(0, 255)));
    run_rec(bq, -1);
  endtask

  initial begin
    int bq[$];
    int t;
    int f0;
    repeat (3) @(negedge clk);
    chk("rst_cs", spi_cs, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    chk("rst_addr", log_addr, BASE);
    rst_n = 1'b1;
    @(negedge clk);

    bq = '{8'h41, 8'h42};
    run_rec(bq, -1);
    bq.delete();
    run_rec(bq, -1);
    bq = '{8'h11, 8'h22, 8'h33};
    run_rec(bq, 1);

    for (int r = 0; r < 16; r++) begin
      if (r % 5 == 4) do_clear();
      rand_rec(int'($urandom_range(0, 6)));
    end

    // abort in the middle of the second header byte
    do_clear();
    f0 = cs_falls;
    @(negedge clk);
    start = 1'b1;
    rec_len = 6'd5;
    t = 0;
    while (cs_falls < f0 + 2 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("hdr_seen", cs_falls - f0, 2);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", spi_cs, 1);
    chk("abort_sclk", spi_clk, 0);
    chk("abort_addr", log_addr, BASE);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    m_addr = BASE;
    m_full = 0;
    mon_q.delete();
    exp_q.delete();
    @(negedge clk);
    rand_rec(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
